fast_line_buffer: RTL and testbench

- Upstream feeder for the FAST corner-detection array (top_arch).
- Converts a raster-order 8-bit pixel stream into seven vertically aligned pixels per column (rows r-6..r), presented on data1..data7 with a load/valid strobe.
- Holds six previous image rows in on-chip line memories, organised as a per-column shift chain.
- Replaces the testbench practice of hand-feeding seven rows in parallel.

---
 rtl/fast_line_buffer.sv | 108 ++++++++++
 tb/tb_fast_line_buffer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fast_line_buffer.sv
// Raster pixel stream to 7-row column window for the FAST corner array.
// Six line memories form a per-column shift chain feeding data1..data6.
module fast_line_buffer #(
  parameter int IMG_W = 200,
  parameter int IMG_H = 200,
  parameter int COL_W = 8,
  parameter int ROW_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [7:0]       in_pix,
  output logic [7:0]       data1,
  output logic [7:0]       data2,
  output logic [7:0]       data3,
  output logic [7:0]       data4,
  output logic [7:0]       data5,
  output logic [7:0]       data6,
  output logic [7:0]       data7,
  output logic             load,
  output logic [COL_W-1:0] col_out,
  output logic [ROW_W-1:0] row_out,
  output logic             frame_done
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0] ROW_FULL = ROW_W'(6);
  localparam logic [ROW_W-1:0] ROW_CTR  = ROW_W'(3);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] c_cur;
  logic [COL_W-1:0] c_nxt;
  logic [ROW_W-1:0] r_cur;
  logic [ROW_W-1:0] r_nxt;
  logic             c_last;
  logic             r_last;

  logic [7:0] lm [6][IMG_W];
  logic [7:0] rd [6];

  // sof forces the pixel to (0,0) whatever the counters say
  always_comb begin
    c_cur  = in_sof ? '0 : col;
    r_cur  = in_sof ? '0 : row;
    c_last = (c_cur == COL_LAST);
    r_last = (r_cur == ROW_LAST);
    c_nxt  = c_last ? '0 : c_cur + COL_W'(1);
    r_nxt  = r_cur;
    if (c_last) begin
      r_nxt = r_last ? '0 : r_cur + ROW_W'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      rd[i] = lm[i][c_cur];
    end
  end

  // line memories are never cleared; load gating hides stale rows
  always_ff @(posedge clk) begin
    if (reset && in_valid) begin
      lm[5][c_cur] <= in_pix;
      for (int i = 0; i < 5; i++) begin
        lm[i][c_cur] <= rd[i+1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col        <= '0;
      row        <= '0;
      data1      <= '0;
      data2      <= '0;
      data3      <= '0;
      data4      <= '0;
      data5      <= '0;
      data6      <= '0;
      data7      <= '0;
      load       <= 1'b0;
      col_out    <= '0;
      row_out    <= '0;
      frame_done <= 1'b0;
    end else if (in_valid) begin
      col        <= c_nxt;
      row        <= r_nxt;
      data7      <= in_pix;
      data6      <= rd[5];
      data5      <= rd[4];
      data4      <= rd[3];
      data3      <= rd[2];
      data2      <= rd[1];
      data1      <= rd[0];
      load       <= (r_cur >= ROW_FULL);
      col_out    <= c_cur;
      row_out    <= r_cur - ROW_CTR;
      frame_done <= !in_sof && r_last && c_last;
    end else begin
      load       <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fast_line_buffer.sv
// Self-checking bench for fast_line_buffer: directed frames plus random
// stream against a frame-image reference model.
module tb_fast_line_buffer;

  localparam int W  = 8;
  localparam int H  = 10;
  localparam int CW = 3;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_sof;
  logic [7:0]    in_pix;
  logic [7:0]    data1, data2, data3, data4, data5, data6, data7;
  logic          load;
  logic [CW-1:0] col_out;
  logic [RW-1:0] row_out;
  logic          frame_done;

  fast_line_buffer #(
    .IMG_W(W), .IMG_H(H), .COL_W(CW), .ROW_W(RW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_sof(in_sof), .in_pix(in_pix),
    .data1(data1), .data2(data2), .data3(data3), .data4(data4),
    .data5(data5), .data6(data6), .data7(data7),
    .load(load), .col_out(col_out), .row_out(row_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int mr, mc;
  int img [H][W];
  int e_d [1:7];
  int e_load, e_fd, e_col, e_row;
  bit known;
  int nload, nfd;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input bit rst, input bit v, input bit s,
                       input int p);
    if (!rst) begin
      mr = 0; mc = 0;
      for (int k = 1; k <= 7; k++) e_d[k] = 0;
      e_load = 0; e_fd = 0; e_col = 0; e_row = 0;
      known = 1;
    end else if (v) begin
      if (s) begin mr = 0; mc = 0; end
      img[mr][mc] = p;
      e_d[7] = p;
      known  = (mr >= 6);
      if (known)
        for (int k = 1; k <= 6; k++) e_d[k] = img[mr-7+k][mc];
      e_load = (mr >= 6);
      e_fd   = (mr == H-1 && mc == W-1);
      e_col  = mc;
      e_row  = (mr - 3) & ((1 << RW) - 1);
      mc++;
      if (mc == W) begin
        mc = 0;
        mr = (mr == H-1) ? 0 : mr + 1;
      end
    end else begin
      e_load = 0; e_fd = 0;
    end
  endtask

  task automatic step(input bit rst, input bit v, input bit s,
                      input int p);
    reset    = rst;
    in_valid = v;
    in_sof   = s;
    in_pix   = 8'(p);
    @(posedge clk);
    model(rst, v, s, p);
    #1;
    check("load", {31'b0, load}, e_load);
    check("frame_done", {31'b0, frame_done}, e_fd);
    check("data7", {24'b0, data7}, e_d[7]);
    check("col_out", {29'b0, col_out}, e_col);
    check("row_out", {28'b0, row_out}, e_row);
    if (known) begin
      check("data1", {24'b0, data1}, e_d[1]);
      check("data2", {24'b0, data2}, e_d[2]);
      check("data3", {24'b0, data3}, e_d[3]);
      check("data4", {24'b0, data4}, e_d[4]);
      check("data5", {24'b0, data5}, e_d[5]);
      check("data6", {24'b0, data6}, e_d[6]);
    end
    if (load) nload++;
    if (frame_done) nfd++;
  endtask

  task automatic pix(input int r, input int c);
    step(1, 1, (r == 0 && c == 0), r*16 + c);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_pix = '0;
    known = 0;

    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'hFF);

    nload = 0; nfd = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) pix(r, c);
    check("loads_frame1", nload, 32);
    check("fd_frame1", nfd, 1);

    nload = 0; nfd = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        pix(r, c);
        if (r == 7 && c == 2)
          for (int g = 0; g < 5; g++) step(1, 0, 0, 8'hAA);
      end
    check("loads_frame2", nload, 32);
    check("fd_frame2", nfd, 1);

    nload = 0; nfd = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (r < 8 || (r == 8 && c < 4)) pix(r, c);
    check("fd_aborted", nfd, 0);
    nload = 0; nfd = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) step(1, 1, (r == 0 && c == 0),
                                       8'h80 ^ (r*16 + c));
    check("loads_after_sof", nload, 32);
    check("fd_after_sof", nfd, 1);

    for (int r = 0; r < 8; r++)
      for (int c = 0; c < W; c++)
        if (r < 7 || c <= 5) pix(r, c);
    step(0, 0, 0, 0);
    nload = 0; nfd = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) step(1, 1, 0, 8'h40 + r*8 + c);
    check("loads_after_rst", nload, 32);
    check("fd_after_rst", nfd, 1);

    step(1, 1, 1, $urandom_range(255));
    for (int i = 0; i < 3000; i++) begin
      bit v, s, rs;
      rs = ($urandom_range(499) != 0);
      v  = ($urandom_range(3) != 0);
      s  = ($urandom_range(399) == 0);
      step(rs, v, s, $urandom_range(255));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
